axis_pattern_tx: RTL and testbench
==================================

# axis_pattern_tx

Stream transmitter that sources 16-bit packets over a tdata/tvalid/tready/tlast handshake. Packets are built from a programmable pattern: incrementing, or a 16-bit Galois LFSR. It is the driving end of the stream link whose receiving end is checked by the `$my_task` VPI monitor. The bench pairs it with a randomly-stalling tready so the monitor sees legal backpressure behaviour instead of a constant word.

## Interface
- DATA_W, 16, stream word width (LFSR mode requires 16)
- LEN_W, 8, width of pkt_len; packet length = pkt_len + 1 words (1..2^LEN_W)
- SEED, 16'd5555, substitute start value when LFSR mode is given base == 0
- clk  in  1  sole clock, all logic on posedge
- rst  in  1  synchronous, active-high reset
- start  in  1  request one packet; sampled only in IDLE
- mode  in  1  0 = incrementing, 1 = LFSR; latched at start
- base  in  DATA_W  first word of packet; latched at start
- pkt_len  in  LEN_W  length minus one; latched at start
- tdata  out  DATA_W  stream data
- tvalid  out  1  stream valid
- tready  in  1  sink ready
- tlast  out  1  high with the final word of a packet
- busy  out  1  high in SEND
- done  out  1  one-cycle pulse after the last word's handshake
- pkt_count  out  16  completed packets, wraps 0xFFFF→0

## Operation
- States: IDLE, SEND.
- IDLE → SEND when start = 1. SEND → IDLE on the handshake (tvalid & tready) of the word with tlast = 1.
- Latch at start:
  - word ← base, or SEED if mode = 1 and base == 0
  - remaining ← pkt_len
  - mode_q ← mode
- On each handshake in SEND:
  - remaining decrements
  - word advances. Mode 0: word + 1 mod 2^16, so 0xFFFF wraps to 0x0000. Mode 1: Galois right-shift, next = (w >> 1) ^ (w[0] ? 16'hB400 : 0).
- Outputs:
  - tdata = word
  - tvalid = (state == SEND)
  - tlast = (state == SEND) & (remaining == 0)
- The stream output follows the AXI-Stream hold rule. While tvalid & !tready, tdata and tlast hold unchanged. tvalid never drops without a handshake (except on rst).
- start in SEND is ignored, including in the cycle of the final handshake. A new packet needs start asserted while in IDLE.
- done and pkt_count increment are registered on the final handshake.
- Reset values:
  - state IDLE
  - tvalid 0, tlast 0, tdata 0
  - busy 0, done 0
  - pkt_count 0
- rst mid-packet: at the next edge the FSM is in IDLE with tvalid = 0. The partial packet is abandoned, with no done pulse and no count.

## Timing
- start sampled high at edge N → tvalid = 1 with the first word after edge N (1-cycle latency).
- With tready held high, one word per cycle. A packet of L words occupies L cycles of tvalid.
- Final handshake at edge M:
  - after M: tvalid = 0, busy = 0, done = 1 for exactly one cycle, pkt_count incremented
  - the earliest next start can be sampled at M+1, giving a minimum 1-cycle gap between packets
- tready has no combinational path to tvalid or tdata. All outputs are registered or decoded from registered state.

## Structure
- Package axis_pattern_pkg holds:
  - state enum {IDLE, SEND}
  - LFSR_TAPS = 16'hB400
  - function lfsr16_next(w)
- No sub-module needed. Single module, roughly 150 lines.

## Test plan
- Incrementing, tready = 1: start with base = 0x0010, pkt_len = 3, mode = 0 → tdata 0x0010, 0x0011, 0x0012, 0x0013 on consecutive cycles. tlast only on 0x0013. done one cycle later, pkt_count = 1.
- LFSR, tready = 1: base = 0, mode = 1, pkt_len = 2 → tdata 0x15B3 (SEED), 0xBED9, 0xEB6C. tlast on 0xEB6C.
- Backpressure: random tready (50%), 16-word incrementing packet →
  - the monitor receives exactly 16 words in order
  - tdata/tlast stable on every tvalid & !tready cycle
  - tvalid never drops mid-packet
- Wrap and ignored start: base = 0xFFFE, pkt_len = 2, start held high throughout →
  - words 0xFFFE, 0xFFFF, 0x0000
  - the second packet begins only after the done cycle
  - pkt_count increments once per packet
- Reset mid-packet: rst for one cycle after the 2nd of 8 words →
  - tvalid = 0 the next cycle, no done pulse, pkt_count unchanged
  - a subsequent start produces a full, correct packet
- Length extremes:
  - pkt_len = 0 → single word, tvalid and tlast both high
  - pkt_len = 255 → 256 words, tlast only on the last

Source files
------------

// File: rtl/axis_pattern_pkg.sv
// Shared types and helpers for the pattern stream transmitter.
package axis_pattern_pkg;

   typedef enum logic {
      IDLE = 1'b0,
      SEND = 1'b1
   } txState_e;

   localparam logic [15:0] LFSR_TAPS = 16'hB400;

   // One step of the right-shifting Galois LFSR used in pattern mode 1.
   function automatic logic [15:0] lfsr16_next(input logic [15:0] w);
      return (w >> 1) ^ (w[0] ? LFSR_TAPS : 16'h0000);
   endfunction

endpackage

// File: rtl/axis_pattern_tx.sv
// Stream transmitter: sources one packet per start request, with words
// generated either by incrementing or by a 16-bit Galois LFSR.
// All stream outputs decode from registered state, so tready never
// reaches tvalid/tdata combinationally and the hold rule comes for free.
module axis_pattern_tx
   import axis_pattern_pkg::*;
#(
   parameter int                DATA_W = 16,
   parameter int                LEN_W  = 8,
   parameter logic [DATA_W-1:0] SEED   = 16'd5555
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic              mode,
   input  logic [DATA_W-1:0] base,
   input  logic [LEN_W-1:0]  pkt_len,
   output logic [DATA_W-1:0] tdata,
   output logic              tvalid,
   input  logic              tready,
   output logic              tlast,
   output logic              busy,
   output logic              done,
   output logic [15:0]       pkt_count
);

   txState_e          state_q;
   logic [DATA_W-1:0] word_q;
   logic [LEN_W-1:0]  remain_q;
   logic              modeSel_q;
   logic              done_q;
   logic [15:0]       pktCount_q;

   logic [DATA_W-1:0] nextWord_d;
   logic [DATA_W-1:0] startWord_d;
   logic              handshake;
   logic              lastWord;

   assign handshake = (state_q == SEND) && tready;
   assign lastWord  = (remain_q == '0);

   // Next pattern word and the first word of a new packet; an all-zero
   // LFSR start would lock up, so SEED stands in for it.
   always_comb begin
      nextWord_d  = word_q + 1'b1;
      startWord_d = base;
      if (modeSel_q) begin
         nextWord_d = lfsr16_next(word_q);
      end
      if (mode && (base == '0)) begin
         startWord_d = SEED;
      end
   end

   // Packet FSM: latch the request in IDLE, advance one word per handshake
   // in SEND, and count/pulse done on the final handshake.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= IDLE;
         word_q     <= '0;
         remain_q   <= '0;
         modeSel_q  <= 1'b0;
         done_q     <= 1'b0;
         pktCount_q <= '0;
      end else begin
         done_q <= 1'b0;
         case (state_q)
            IDLE: begin
               if (start) begin
                  word_q    <= startWord_d;
                  remain_q  <= pkt_len;
                  modeSel_q <= mode;
                  state_q   <= SEND;
               end
            end
            SEND: begin
               if (handshake) begin
                  word_q <= nextWord_d;
                  if (lastWord) begin
                     state_q    <= IDLE;
                     done_q     <= 1'b1;
                     pktCount_q <= pktCount_q + 16'd1;
                  end else begin
                     remain_q <= remain_q - 1'b1;
                  end
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign tdata     = word_q;
   assign tvalid    = (state_q == SEND);
   assign tlast     = (state_q == SEND) && lastWord;
   assign busy      = (state_q == SEND);
   assign done      = done_q;
   assign pkt_count = pktCount_q;

endmodule

// File: tb/tb_axis_pattern_tx.sv
// Directed bench for axis_pattern_tx: drives inputs and samples outputs on
// the falling edge, comparing against hand-derived word sequences.
module tb_axis_pattern_tx;

   logic        clk = 1'b0;
   logic        rst;
   logic        start;
   logic        mode;
   logic [15:0] base;
   logic [7:0]  pkt_len;
   logic [15:0] tdata;
   logic        tvalid;
   logic        tready;
   logic        tlast;
   logic        busy;
   logic        done;
   logic [15:0] pkt_count;

   int nAsserts = 0;
   int nFails   = 0;

   logic [15:0] expQ[$];

   axis_pattern_tx dut (
      .clk       (clk),
      .rst       (rst),
      .start     (start),
      .mode      (mode),
      .base      (base),
      .pkt_len   (pkt_len),
      .tdata     (tdata),
      .tvalid    (tvalid),
      .tready    (tready),
      .tlast     (tlast),
      .busy      (busy),
      .done      (done),
      .pkt_count (pkt_count)
   );

   // Free-running clock, 10 time units per cycle.
   always #5 clk = ~clk;

   // Global time bound so a stuck design still ends the run.
   initial begin
      #200000;
      $display("[TB] FAIL watchdog expired observed=timeout expected=finish");
      $fatal(1, "[TB] watchdog");
   end

   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      nAsserts++;
      assert (observed === expected) else begin
         nFails++;
         $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
      end
   endtask

   task automatic applyStimulus(input logic st, input logic md,
                                input logic [15:0] bs, input logic [7:0] lenM1);
      start   = st;
      mode    = md;
      base    = bs;
      pkt_len = lenM1;
   endtask

   function automatic void fillInc(input logic [15:0] b, input int n);
      expQ.delete();
      for (int i = 0; i < n; i++) begin
         expQ.push_back(b + 16'(i));
      end
   endfunction

   // Requests one packet and checks every presented word against expWords;
   // with rndReady the sink stalls at random, so held words are rechecked.
   task automatic runPacket(input string tag, input logic md, input logic [15:0] bs,
                            input logic [7:0] lenM1, input bit rndReady,
                            input bit holdStart, input logic [15:0] expWords[$],
                            input logic [15:0] expCount);
      int got;
      int guard;
      bit stall;
      got   = 0;
      guard = 0;
      applyStimulus(1'b1, md, bs, lenM1);
      tready = 1'b1;
      @(negedge clk);
      if (!holdStart) start = 1'b0;
      while ((got < expWords.size()) && (guard < 4000)) begin
         checkOutput({tag, ".tvalid"}, 32'(tvalid), 32'd1);
         checkOutput({tag, ".busy"}, 32'(busy), 32'd1);
         checkOutput({tag, ".doneLow"}, 32'(done), 32'd0);
         checkOutput({tag, ".tdata"}, 32'(tdata), 32'(expWords[got]));
         checkOutput({tag, ".tlast"}, 32'(tlast), 32'(got == expWords.size() - 1));
         tready = rndReady ? 1'($urandom_range(0, 1)) : 1'b1;
         stall  = !tready;
         @(negedge clk);
         if (!stall) got++;
         guard++;
      end
      checkOutput({tag, ".wordsSent"}, 32'(got), 32'(expWords.size()));
      checkOutput({tag, ".tvalidAfter"}, 32'(tvalid), 32'd0);
      checkOutput({tag, ".tlastAfter"}, 32'(tlast), 32'd0);
      checkOutput({tag, ".busyAfter"}, 32'(busy), 32'd0);
      checkOutput({tag, ".donePulse"}, 32'(done), 32'd1);
      checkOutput({tag, ".pktCount"}, 32'(pkt_count), 32'(expCount));
      tready = 1'b1;
   endtask

   // Linear sequence of directed scenarios.
   initial begin
      rst    = 1'b1;
      tready = 1'b1;
      applyStimulus(1'b0, 1'b0, 16'h0000, 8'd0);
      @(negedge clk);
      @(negedge clk);
      checkOutput("reset.tvalid", 32'(tvalid), 32'd0);
      checkOutput("reset.tlast", 32'(tlast), 32'd0);
      checkOutput("reset.tdata", 32'(tdata), 32'd0);
      checkOutput("reset.busy", 32'(busy), 32'd0);
      checkOutput("reset.done", 32'(done), 32'd0);
      checkOutput("reset.pktCount", 32'(pkt_count), 32'd0);
      rst = 1'b0;
      @(negedge clk);
      checkOutput("idle.tvalid", 32'(tvalid), 32'd0);

      // Reset mid-packet: two words accepted of eight, then rst for one cycle.
      applyStimulus(1'b1, 1'b0, 16'h0100, 8'd7);
      @(negedge clk);
      start = 1'b0;
      checkOutput("rstMid.word0", 32'(tdata), 32'h0100);
      @(negedge clk);
      checkOutput("rstMid.word1", 32'(tdata), 32'h0101);
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      checkOutput("rstMid.tvalid", 32'(tvalid), 32'd0);
      checkOutput("rstMid.tlast", 32'(tlast), 32'd0);
      checkOutput("rstMid.busy", 32'(busy), 32'd0);
      checkOutput("rstMid.done", 32'(done), 32'd0);
      checkOutput("rstMid.pktCount", 32'(pkt_count), 32'd0);
      @(negedge clk);
      checkOutput("rstMid.noLateDone", 32'(done), 32'd0);
      checkOutput("rstMid.stillIdle", 32'(tvalid), 32'd0);

      // Full packet after the abandoned one.
      fillInc(16'h0100, 8);
      runPacket("rstRecover", 1'b0, 16'h0100, 8'd7, 1'b0, 1'b0, expQ, 16'd1);

      // Incrementing, four words.
      fillInc(16'h0010, 4);
      runPacket("inc4", 1'b0, 16'h0010, 8'd3, 1'b0, 1'b0, expQ, 16'd2);
      @(negedge clk);
      checkOutput("inc4.doneOneCycle", 32'(done), 32'd0);

      // LFSR from zero base: SEED substitution then two Galois steps.
      expQ = {16'h15B3, 16'hBED9, 16'hEB6C};
      runPacket("lfsr", 1'b1, 16'h0000, 8'd2, 1'b0, 1'b0, expQ, 16'd3);
      @(negedge clk);

      // Random backpressure, sixteen incrementing words.
      fillInc(16'h2000, 16);
      runPacket("bkpr", 1'b0, 16'h2000, 8'd15, 1'b1, 1'b0, expQ, 16'd4);
      @(negedge clk);

      // Wrap through 0xFFFF with start held high across two packets.
      expQ = {16'hFFFE, 16'hFFFF, 16'h0000};
      runPacket("wrapA", 1'b0, 16'hFFFE, 8'd2, 1'b0, 1'b1, expQ, 16'd5);
      runPacket("wrapB", 1'b0, 16'hFFFE, 8'd2, 1'b0, 1'b1, expQ, 16'd6);
      start = 1'b0;
      @(negedge clk);
      checkOutput("wrap.idleTvalid", 32'(tvalid), 32'd0);
      checkOutput("wrap.doneLow", 32'(done), 32'd0);
      checkOutput("wrap.pktCount", 32'(pkt_count), 32'd6);

      // Shortest packet: one word, tvalid and tlast together.
      fillInc(16'hABCD, 1);
      runPacket("len1", 1'b0, 16'hABCD, 8'd0, 1'b0, 1'b0, expQ, 16'd7);
      @(negedge clk);

      // Longest packet: 256 words, tlast only on the final one.
      fillInc(16'h1234, 256);
      runPacket("len256", 1'b0, 16'h1234, 8'd255, 1'b0, 1'b0, expQ, 16'd8);
      @(negedge clk);
      checkOutput("final.idle", 32'(tvalid), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", nAsserts, nFails);
      $finish;
   end

endmodule
